// File: rtl/song_rx_loader_pkg.sv
// rtl/song_rx_loader_pkg.sv - shared types, constants and byte placement helper for the song loader
package song_rx_loader_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CSUM, COMMIT} rx_state_t;

    localparam logic [7:0] SONG_HEADER = 8'hA5;

    // Bit offset of data byte k inside the packed lane vector:
    // lane k/bytes_per_lane, MSB-first within that lane.
    function automatic int byte_pos(input int k, input int lane_bits);
        int bpl;
        bpl = lane_bits / 8;
        return (k / bpl) * lane_bits + (bpl - 1 - (k % bpl)) * 8;
    endfunction

endpackage

// File: rtl/song_rx_loader_if.sv
// rtl/song_rx_loader_if.sv - UART byte receive/echo handshake bundle
// master: host/UART side (drives rxdata, rxready, txready)
// slave : loader side (drives rxclk, txdata, txclk)
interface song_rx_loader_if;
    logic [7:0] rxdata;
    logic       rxready;
    logic       rxclk;
    logic [7:0] txdata;
    logic       txready;
    logic       txclk;

    modport master (output rxdata, rxready, txready, input rxclk, txdata, txclk);
    modport slave  (input rxdata, rxready, txready, output rxclk, txdata, txclk);
endinterface

// File: rtl/song_rx_loader_rx_byte_pop.sv
// rtl/song_rx_loader_rx_byte_pop.sv - byte accept rule and registered one-cycle pop strobe
// Ports: hwclk/reset (async, active-high), en, rxdata/rxready from the UART,
//        rxclk pop strobe back to it, byte_valid/byte_data to the packet FSM.
module rx_byte_pop (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] rxdata,
    input  logic       rxready,
    output logic       rxclk,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    logic rxclk_q, rxclk_d;

    // The sender still shows rxready during the strobe cycle, so a byte
    // is never taken while rxclk is high; this caps intake at 1 byte / 2 cycles.
    always_comb begin
        byte_valid = en && rxready && !rxclk_q;
        rxclk_d    = byte_valid;
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) rxclk_q <= 1'b0;
        else       rxclk_q <= rxclk_d;
    end

    assign rxclk     = rxclk_q;
    assign byte_data = rxdata;
endmodule

// File: rtl/song_rx_loader.sv
// rtl/song_rx_loader.sv - song upload packet parser building note-lane bitmaps
// Ports: hwclk, reset (async, active-high), en (editor mode), uart (slave side of
//        song_rx_loader_if), notes_out (lane i at [i*LANE_BITS +: LANE_BITS]),
//        load_done / load_err one-cycle pulses, busy (state != IDLE).
// Packet: HEADER, NUM_LANES*LANE_BITS/8 data bytes, XOR checksum of the data bytes.
// Build option: SONG_RX_ECHO_EN echoes every accepted byte on txdata/txclk.
module song_rx_loader
    import song_rx_loader_pkg::*;
#(
    parameter int         NUM_LANES   = 2,
    parameter int         LANE_BITS   = 32,
    parameter int         TIMEOUT_CYC = 12_000_000,
    parameter logic [7:0] HEADER      = SONG_HEADER
) (
    input  logic                           hwclk,
    input  logic                           reset,
    input  logic                           en,
    song_rx_loader_if.slave                uart,
    output logic [NUM_LANES*LANE_BITS-1:0] notes_out,
    output logic                           load_done,
    output logic                           load_err,
    output logic                           busy
);
    localparam int NB = NUM_LANES * LANE_BITS / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int VW = NUM_LANES * LANE_BITS;

    logic       rxclk, byte_valid;
    logic [7:0] byte_data;

    rx_byte_pop u_pop (
        .hwclk      (hwclk),
        .reset      (reset),
        .en         (en),
        .rxdata     (uart.rxdata),
        .rxready    (uart.rxready),
        .rxclk      (rxclk),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );
    assign uart.rxclk = rxclk;

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        xor_q, xor_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic [VW-1:0]     notes_q, notes_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        xor_d    = xor_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        notes_d  = notes_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (!en) begin
            // Leaving editor mode silently drops any partial packet.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (byte_valid && byte_data == HEADER) begin
                        state_d = DATA;
                        count_d = '0;
                        xor_d   = '0;
                        timer_d = '0;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        for (int k = 0; k < NB; k++) begin
                            if (count_q == CW'(k)) shadow_d[byte_pos(k, LANE_BITS) +: 8] = byte_data;
                        end
                        xor_d   = xor_q ^ byte_data;
                        count_d = count_q + 1'b1;
                        timer_d = '0;
                        if (count_q == CW'(NB - 1)) state_d = CSUM;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                CSUM: begin
                    if (byte_valid) begin
                        timer_d = '0;
                        if (byte_data == xor_q) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                COMMIT: begin
                    notes_d = shadow_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            xor_q    <= '0;
            timer_q  <= '0;
            shadow_q <= '0;
            notes_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            xor_q    <= xor_d;
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
            notes_q  <= notes_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign notes_out = notes_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign busy      = (state_q != IDLE);

`ifdef SONG_RX_ECHO_EN
    logic [7:0] txdata_q, txdata_d;

    // Echo is best effort: if the transmitter is not ready the byte is dropped.
    always_comb begin
        txdata_d = byte_valid ? byte_data : txdata_q;
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) txdata_q <= 8'h00;
        else       txdata_q <= txdata_d;
    end

    assign uart.txdata = txdata_q;
    assign uart.txclk  = rxclk && uart.txready;
`else
    assign uart.txdata = 8'h00;
    assign uart.txclk  = 1'b0;
    wire unused_txready = uart.txready;
`endif
endmodule

// File: tb/tb_song_rx_loader.sv
// tb/tb_song_rx_loader.sv - directed table-driven bench for song_rx_loader
module tb_song_rx_loader;
    logic        hwclk = 1'b0;
    logic        reset;
    logic        en;
    logic [63:0] notes_out;
    logic        load_done, load_err, busy;

    always #5 hwclk = ~hwclk;

    song_rx_loader_if u_if ();

    song_rx_loader #(
        .NUM_LANES   (2),
        .LANE_BITS   (32),
        .TIMEOUT_CYC (50),
        .HEADER      (8'hA5)
    ) dut (
        .hwclk     (hwclk),
        .reset     (reset),
        .en        (en),
        .uart      (u_if.slave),
        .notes_out (notes_out),
        .load_done (load_done),
        .load_err  (load_err),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] bytes;      // data byte 0 at [63:56]
        logic [7:0]  cs;
        logic        exp_done;
        logic [63:0] exp_notes;
    } vec_t;

    vec_t vecs [6];
    int total = 0;
    int bad   = 0;
    int n_done = 0, n_err = 0, n_pop = 0, n_both = 0;

    always @(negedge hwclk) begin
        if (load_done) n_done++;
        if (load_err)  n_err++;
        if (u_if.rxclk) n_pop++;
        if (load_done && load_err) n_both++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    task automatic clear_counts();
        n_done = 0; n_err = 0; n_pop = 0; n_both = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        u_if.rxdata  = b;
        u_if.rxready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (u_if.rxclk) got = 1'b1;
        end
        u_if.rxready = 1'b0;
        if (!got) begin
            chk("pop_wait_expired", 64'd0, 64'd1);
        end else begin
`ifdef SONG_RX_ECHO_EN
            chk("echo_txdata", {56'd0, u_if.txdata}, {56'd0, b});
            chk("echo_txclk", {63'd0, u_if.txclk}, {63'd0, u_if.txready});
`else
            chk("txclk_idle", {63'd0, u_if.txclk}, 64'd0);
            chk("txdata_idle", {56'd0, u_if.txdata}, 64'd0);
`endif
        end
    endtask

    task automatic send_packet(input logic [63:0] bytes, input logic [7:0] cs,
                               input logic exp_done, input string tag);
        send_byte(8'hA5);
        for (int k = 0; k < 8; k++) send_byte(bytes[63-8*k -: 8]);
        send_byte(cs);
        step();
        chk({tag, "_done_timing"}, {63'd0, load_done}, {63'd0, exp_done});
        repeat (3) step();
    endtask

    initial begin
        vecs[0] = '{64'hCCCCCCCC_AAAAAAAA, 8'h00, 1'b1, 64'hAAAAAAAA_CCCCCCCC};
        vecs[1] = '{64'hCCCCCCCC_AAAAAAAA, 8'h01, 1'b0, 64'hAAAAAAAA_CCCCCCCC};
        vecs[2] = '{64'h01020304_05060708, 8'h08, 1'b1, 64'h05060708_01020304};
        vecs[3] = '{64'hA5A5A5A5_00000000, 8'h00, 1'b1, 64'h00000000_A5A5A5A5};
        vecs[4] = '{64'h12345678_9ABCDEF0, 8'hFF, 1'b0, 64'h00000000_A5A5A5A5};
        vecs[5] = '{64'hFFFFFFFF_00000001, 8'h01, 1'b1, 64'h00000001_FFFFFFFF};

        reset = 1'b1; en = 1'b0;
        u_if.rxdata = 8'h00; u_if.rxready = 1'b0; u_if.txready = 1'b1;
        repeat (3) step();
        chk("rst_notes", notes_out, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, load_done}, 64'd0);
        chk("rst_err", {63'd0, load_err}, 64'd0);
        chk("rst_rxclk", {63'd0, u_if.rxclk}, 64'd0);
        chk("rst_txclk", {63'd0, u_if.txclk}, 64'd0);
        chk("rst_txdata", {56'd0, u_if.txdata}, 64'd0);
        reset = 1'b0; en = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            clear_counts();
            send_packet(vecs[v].bytes, vecs[v].cs, vecs[v].exp_done, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_done_cnt", v), 64'(n_done), 64'(vecs[v].exp_done));
            chk($sformatf("vec%0d_err_cnt", v), 64'(n_err), 64'(!vecs[v].exp_done));
            chk($sformatf("vec%0d_notes", v), notes_out, vecs[v].exp_notes);
            chk($sformatf("vec%0d_busy", v), {63'd0, busy}, 64'd0);
            chk($sformatf("vec%0d_excl", v), 64'(n_both), 64'd0);
            chk($sformatf("vec%0d_pops", v), 64'(n_pop), 64'd10);
        end

        // Garbage before a packet, echo transmitter not ready.
        clear_counts();
        u_if.txready = 1'b0;
        send_byte(8'h3C);
        send_byte(8'h11);
        u_if.txready = 1'b1;
        repeat (3) step();
        chk("garbage_pops", 64'(n_pop), 64'd2);
        chk("garbage_done", 64'(n_done), 64'd0);
        chk("garbage_err", 64'(n_err), 64'd0);
        chk("garbage_busy", {63'd0, busy}, 64'd0);
        chk("garbage_notes", notes_out, 64'h00000001_FFFFFFFF);
        clear_counts();
        send_packet(vecs[0].bytes, vecs[0].cs, 1'b1, "after_garbage");
        chk("after_garbage_notes", notes_out, 64'hAAAAAAAA_CCCCCCCC);
        chk("after_garbage_done", 64'(n_done), 64'd1);

        // Stall three bytes into the data phase.
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("stall_busy", {63'd0, busy}, 64'd1);
        repeat (60) step();
        chk("timeout_err", 64'(n_err), 64'd1);
        chk("timeout_done", 64'(n_done), 64'd0);
        chk("timeout_busy", {63'd0, busy}, 64'd0);
        chk("timeout_notes", notes_out, 64'hAAAAAAAA_CCCCCCCC);
        clear_counts();
        send_packet(vecs[2].bytes, vecs[2].cs, 1'b1, "after_timeout");
        chk("after_timeout_notes", notes_out, 64'h05060708_01020304);

        // Drop en after byte 5.
        clear_counts();
        send_byte(8'hA5);
        for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k));
        en = 1'b0;
        step();
        chk("en_drop_busy", {63'd0, busy}, 64'd0);
        u_if.rxdata = 8'hA5; u_if.rxready = 1'b1;
        repeat (4) step();
        chk("en_drop_no_pop", 64'(n_pop), 64'd6);
        u_if.rxready = 1'b0;
        en = 1'b1;
        repeat (2) step();
        chk("en_drop_done", 64'(n_done), 64'd0);
        chk("en_drop_err", 64'(n_err), 64'd0);
        chk("en_drop_notes", notes_out, 64'h05060708_01020304);

        // Reset after byte 5.
        clear_counts();
        send_byte(8'hA5);
        for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k));
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_notes", notes_out, 64'd0);
        step();
        reset = 1'b0;
        repeat (2) step();
        chk("rst_mid_done", 64'(n_done), 64'd0);
        chk("rst_mid_err", 64'(n_err), 64'd0);
        clear_counts();
        send_packet(vecs[5].bytes, vecs[5].cs, 1'b1, "after_reset");
        chk("after_reset_notes", notes_out, 64'h00000001_FFFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
